imem_port_arbiter: RTL and testbench
====================================

# imem_port_arbiter

Shares the single port of the 16-word × 16-bit instruction memory between the CPU fetch path (read) and the program loader (write). Grants one requester per cycle, drives the memory address/write strobes, and returns registered fetch data with a one-cycle valid pulse. The loader has priority, bounded by a fairness counter so that fetch is never starved. The block sits between the PC/fetch stage, the boot loader and the instruction memory array. The memory array has a combinational read and a synchronous write.

## Interface
- `ADDR_W`, 4, word address width (memory depth = 2^ADDR_W).
- `DATA_W`, 16, instruction word width.
- `MAX_LOAD_BURST`, 4, maximum consecutive load grants while a fetch is pending (range 1..15).

- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `fetch_req` in 1: fetch request; held until `fetch_gnt`.
- `fetch_pc` in 16: byte PC; word address = `fetch_pc[ADDR_W:1]`.
- `fetch_gnt` out 1: combinational; fetch owns the port this cycle.
- `fetch_valid` out 1: registered; one-cycle pulse the cycle after `fetch_gnt`.
- `fetch_instr` out DATA_W: registered instruction; holds its value between fetches.
- `fetch_misalign` out 1: registered; equals `fetch_pc[0]` of the granted fetch, valid with `fetch_valid`.
- `load_req` in 1: write request; held until `load_gnt`.
- `load_addr` in ADDR_W: word address to write.
- `load_data` in DATA_W: word to write.
- `load_gnt` out 1: combinational; the write commits at this cycle's rising edge.
- `mem_addr` out ADDR_W: combinational memory address.
- `mem_we` out 1: combinational write enable (= `load_gnt`).
- `mem_wdata` out DATA_W: combinational write data (= `load_data`).
- `mem_rdata` in DATA_W: combinational read data from the array.
- `load_count` out ADDR_W+1: registered count of committed writes; saturates at 2^ADDR_W.

## Operation
- Grant decision each cycle (combinational, from the inputs and `burst_cnt`):
  - Neither request: no grant.
  - Only one request: that requester is granted.
  - Both requests and `burst_cnt < MAX_LOAD_BURST`: load is granted.
  - Both requests and `burst_cnt == MAX_LOAD_BURST`: fetch is granted.
- At most one of `fetch_gnt` / `load_gnt` is high in any cycle.
- `burst_cnt` (4 bits, internal):
  - Increments on a load grant while `fetch_req` = 1.
  - Clears on a fetch grant, or on any cycle with `fetch_req` = 0.
- `mem_addr` selection:
  - `load_addr` when load is granted.
  - `fetch_pc[ADDR_W:1]` otherwise, including idle cycles.
- `mem_we` = `load_gnt`. Nothing else writes the memory.
- Fetch grant: at the edge, `fetch_instr` <= `mem_rdata`, `fetch_misalign` <= `fetch_pc[0]`, and `fetch_valid` is high for the following cycle.
- `fetch_pc[15:ADDR_W+1]` is ignored; addresses wrap modulo 16 words.
- Grant-state register `gstate` ∈ {IDLE, FETCH, LOAD} records the previous cycle's grant:
  - Next state is FETCH on fetch grant, LOAD on load grant, IDLE otherwise.
  - `fetch_valid` = (`gstate` == FETCH).
- `load_count` increments on each load grant and stops at 16.

## Timing
- Reset (asynchronous, immediate) sets:
  - `fetch_valid`=0, `fetch_instr`=0, `fetch_misalign`=0, `load_count`=0, `burst_cnt`=0, `gstate`=IDLE.
  - `fetch_gnt`/`load_gnt`/`mem_we` follow the inputs combinationally but are forced to 0 while `rst`=1.
- Fetch latency: request is granted in cycle N (earliest); data appears on `fetch_instr` with `fetch_valid`=1 in cycle N+1.
- Load: the write is visible to a fetch granted in cycle N+1 (write-then-read, same address → new data).
- Back-to-back fetches: one per cycle, with `fetch_valid` continuously high.
- `rst` asserted in the cycle after a fetch grant: the `fetch_valid` pulse is suppressed and no write is pending.
- `load_req` dropped in the same cycle that `MAX_LOAD_BURST` is reached: fetch is granted normally.

## Test plan
- Reset, then `fetch_req`=1, `fetch_pc`=0x0006 with mem[3]=0xA5C3 → `fetch_gnt`=1 in cycle 0; in cycle 1 `fetch_valid`=1, `fetch_instr`=0xA5C3, `fetch_misalign`=0.
- Loader writes 0x1111..0xFFFF to addresses 0..14 back-to-back, no fetch → 15 consecutive `load_gnt` pulses, `load_count`=15, memory contents match.
- `fetch_req` and `load_req` both held high for 12 cycles, MAX_LOAD_BURST=4 → grant pattern L,L,L,L,F,L,L,L,L,F,L,L.
- Load 0xBEEF to address 5 in cycle N, fetch `fetch_pc`=0x000A granted in cycle N+1 → `fetch_instr`=0xBEEF in cycle N+2.
- `fetch_pc`=0x0023 → `mem_addr`=1 (wrap), `fetch_misalign`=1 with `fetch_valid`.
- Assert `rst` mid-cycle after a fetch grant, with `load_count`=7 → all registered outputs are 0 immediately and no `fetch_valid` pulse occurs.

Source files
------------

// File: rtl/imem_port_arbiter_if.sv
// Shared instruction-memory port bundle: fetch requester, loader requester and memory array side.
// The arbiter connects through the slave modport; the requesters and array sit on the master side.
interface imem_port_arbiter_if #(
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned DATA_W = 16
);
    logic              fetch_req;
    logic [15:0]       fetch_pc;
    logic              fetch_gnt;
    logic              fetch_valid;
    logic [DATA_W-1:0] fetch_instr;
    logic              fetch_misalign;

    logic              load_req;
    logic [ADDR_W-1:0] load_addr;
    logic [DATA_W-1:0] load_data;
    logic              load_gnt;
    logic [ADDR_W:0]   load_count;

    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  fetch_req, fetch_pc, load_req, load_addr, load_data, mem_rdata,
        output fetch_gnt, fetch_valid, fetch_instr, fetch_misalign,
        output load_gnt, load_count, mem_addr, mem_we, mem_wdata
    );

    modport master (
        output fetch_req, fetch_pc, load_req, load_addr, load_data, mem_rdata,
        input  fetch_gnt, fetch_valid, fetch_instr, fetch_misalign,
        input  load_gnt, load_count, mem_addr, mem_we, mem_wdata
    );
endinterface

// File: rtl/imem_port_arbiter.sv
// Single-port instruction memory arbiter: loader-priority writes with a burst limit so fetch
// is never starved, registered fetch data with a one-cycle valid pulse.
module imem_port_arbiter #(
    parameter int unsigned ADDR_W         = 4,
    parameter int unsigned DATA_W         = 16,
    parameter int unsigned MAX_LOAD_BURST = 4
) (
    input logic                clk,
    input logic                rst,
    imem_port_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, FETCH, LOAD} gstate_e;

    localparam logic [3:0]      BURST_MAX = 4'(MAX_LOAD_BURST);
    localparam logic [ADDR_W:0] COUNT_MAX = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] COUNT_ONE = {{ADDR_W{1'b0}}, 1'b1};

    gstate_e           gstate_q, gstate_d;
    logic [3:0]        burst_cnt_q, burst_cnt_d;
    logic [DATA_W-1:0] fetch_instr_q, fetch_instr_d;
    logic              fetch_misalign_q, fetch_misalign_d;
    logic [ADDR_W:0]   load_count_q, load_count_d;

    logic              fetch_gnt;
    logic              load_gnt;
    logic [ADDR_W-1:0] fetch_word;
    logic              unused_pc_hi;

    // Byte PC to word address; upper PC bits are dropped so addresses wrap.
    assign fetch_word   = bus.fetch_pc[ADDR_W:1];
    assign unused_pc_hi = ^bus.fetch_pc[15:ADDR_W+1];

    always_comb begin
        fetch_gnt = 1'b0;
        load_gnt  = 1'b0;
        if (!rst) begin
            if (bus.load_req && (!bus.fetch_req || (burst_cnt_q < BURST_MAX))) begin
                load_gnt = 1'b1;
            end else if (bus.fetch_req) begin
                fetch_gnt = 1'b1;
            end
        end
    end

    always_comb begin
        gstate_d         = IDLE;
        burst_cnt_d      = burst_cnt_q;
        fetch_instr_d    = fetch_instr_q;
        fetch_misalign_d = fetch_misalign_q;
        load_count_d     = load_count_q;

        if (fetch_gnt) begin
            gstate_d         = FETCH;
            fetch_instr_d    = bus.mem_rdata;
            fetch_misalign_d = bus.fetch_pc[0];
        end else if (load_gnt) begin
            gstate_d = LOAD;
        end

        // Burst only accumulates while a fetch is actually waiting.
        if (fetch_gnt || !bus.fetch_req) begin
            burst_cnt_d = '0;
        end else if (load_gnt) begin
            burst_cnt_d = burst_cnt_q + 4'd1;
        end

        if (load_gnt && (load_count_q != COUNT_MAX)) begin
            load_count_d = load_count_q + COUNT_ONE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gstate_q         <= IDLE;
            burst_cnt_q      <= '0;
            fetch_instr_q    <= '0;
            fetch_misalign_q <= 1'b0;
            load_count_q     <= '0;
        end else begin
            gstate_q         <= gstate_d;
            burst_cnt_q      <= burst_cnt_d;
            fetch_instr_q    <= fetch_instr_d;
            fetch_misalign_q <= fetch_misalign_d;
            load_count_q     <= load_count_d;
        end
    end

    assign bus.fetch_gnt      = fetch_gnt;
    assign bus.load_gnt       = load_gnt;
    assign bus.mem_we         = load_gnt;
    assign bus.mem_wdata      = bus.load_data;
    assign bus.mem_addr       = load_gnt ? bus.load_addr : fetch_word;
    assign bus.fetch_valid    = (gstate_q == FETCH);
    assign bus.fetch_instr    = fetch_instr_q;
    assign bus.fetch_misalign = fetch_misalign_q;
    assign bus.load_count     = load_count_q;
endmodule

// File: tb/tb_imem_port_arbiter.sv
// Bench for imem_port_arbiter: behavioural memory array, vector table for grant patterns,
// scoreboard of expected fetch results, hand sequences for reset and write-then-read.
module tb_imem_port_arbiter;
    logic clk;
    logic rst;
    logic mem_ready;

    imem_port_arbiter_if #(.ADDR_W(4), .DATA_W(16)) bus ();

    imem_port_arbiter #(
        .ADDR_W(4),
        .DATA_W(16),
        .MAX_LOAD_BURST(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct packed {
        logic [15:0] instr;
        logic        mis;
    } sb_t;

    typedef struct {
        logic        fr;
        logic [15:0] pc;
        logic        lr;
        logic [3:0]  la;
        logic [15:0] ld;
        logic        efg;
        logic        elg;
    } vec_t;

    logic [15:0] tb_mem  [16];
    logic [15:0] ref_mem [16];
    sb_t         sb_q [$];
    vec_t        vt [12];
    int          checks;
    int          errors;
    int          ref_count;
    logic [15:0] last_instr;
    logic        last_mis;

    localparam logic [0:11] FPAT = 12'b000010000100;

    function automatic logic [15:0] init_word(input int i);
        return (i == 3) ? 16'hA5C3 : 16'(16'h2000 + 257 * i);
    endfunction

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory array: combinational read, synchronous write.
    assign bus.mem_rdata = tb_mem[bus.mem_addr];
    always @(posedge clk) begin
        if (!mem_ready) begin
            for (int i = 0; i < 16; i++) tb_mem[i] <= init_word(i);
        end else if (bus.mem_we) begin
            tb_mem[bus.mem_addr] <= bus.mem_wdata;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input logic fr, input logic [15:0] pc, input logic lr,
                        input logic [3:0] la, input logic [15:0] ld,
                        input logic efg, input logic elg);
        logic [3:0] eaddr;
        sb_t        got;
        @(negedge clk);
        bus.fetch_req = fr;
        bus.fetch_pc  = pc;
        bus.load_req  = lr;
        bus.load_addr = la;
        bus.load_data = ld;
        #1;
        eaddr = elg ? la : pc[4:1];
        chk("fetch_gnt", 32'(bus.fetch_gnt), 32'(efg));
        chk("load_gnt", 32'(bus.load_gnt), 32'(elg));
        chk("mem_we", 32'(bus.mem_we), 32'(elg));
        chk("mem_addr", 32'(bus.mem_addr), 32'(eaddr));
        if (elg) chk("mem_wdata", 32'(bus.mem_wdata), 32'(ld));
        if (efg) sb_q.push_back('{instr: ref_mem[pc[4:1]], mis: pc[0]});
        if (elg) begin
            ref_mem[la] = ld;
            if (ref_count != 16) ref_count++;
        end
        @(posedge clk);
        #1;
        chk("fetch_valid", 32'(bus.fetch_valid), 32'(efg));
        if (bus.fetch_valid) begin
            if (sb_q.size() == 0) begin
                chk("sb_unexpected_valid", 32'(1), 32'(0));
            end else begin
                got = sb_q.pop_front();
                chk("fetch_instr", 32'(bus.fetch_instr), 32'(got.instr));
                chk("fetch_misalign", 32'(bus.fetch_misalign), 32'(got.mis));
                last_instr = got.instr;
                last_mis   = got.mis;
            end
        end else begin
            chk("fetch_instr_hold", 32'(bus.fetch_instr), 32'(last_instr));
            chk("fetch_misalign_hold", 32'(bus.fetch_misalign), 32'(last_mis));
        end
        chk("load_count", 32'(bus.load_count), 32'(ref_count));
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst           = 1'b1;
        bus.fetch_req = 1'b1;
        bus.load_req  = 1'b1;
        #1;
        chk("rst_fetch_gnt", 32'(bus.fetch_gnt), 32'(0));
        chk("rst_load_gnt", 32'(bus.load_gnt), 32'(0));
        chk("rst_mem_we", 32'(bus.mem_we), 32'(0));
        chk("rst_fetch_valid", 32'(bus.fetch_valid), 32'(0));
        chk("rst_fetch_instr", 32'(bus.fetch_instr), 32'(0));
        chk("rst_fetch_misalign", 32'(bus.fetch_misalign), 32'(0));
        chk("rst_load_count", 32'(bus.load_count), 32'(0));
        @(negedge clk);
        rst           = 1'b0;
        bus.fetch_req = 1'b0;
        bus.load_req  = 1'b0;
        ref_count     = 0;
        last_instr    = '0;
        last_mis      = 1'b0;
        sb_q.delete();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        checks        = 0;
        errors        = 0;
        ref_count     = 0;
        last_instr    = '0;
        last_mis      = 1'b0;
        mem_ready     = 1'b0;
        rst           = 1'b1;
        bus.fetch_req = 1'b0;
        bus.fetch_pc  = '0;
        bus.load_req  = 1'b0;
        bus.load_addr = '0;
        bus.load_data = '0;
        for (int i = 0; i < 16; i++) ref_mem[i] = init_word(i);

        for (int k = 0; k < 12; k++) begin
            vt[k] = '{fr: 1'b1, pc: 16'(4 * k), lr: 1'b1, la: 4'hF, ld: 16'(16'hC000 + k),
                      efg: FPAT[k], elg: !FPAT[k]};
        end

        do_reset();
        mem_ready = 1'b1;

        // First fetch after reset.
        step(1'b1, 16'h0006, 1'b0, 4'h0, 16'h0000, 1'b1, 1'b0);
        chk("first_fetch_instr", 32'(bus.fetch_instr), 32'(16'hA5C3));
        step(1'b0, 16'h0006, 1'b0, 4'h0, 16'h0000, 1'b0, 1'b0);

        // Back-to-back loads to 0..14 with no fetch pending.
        for (int i = 0; i < 15; i++) begin
            step(1'b0, 16'h0000, 1'b1, 4'(i), 16'(16'h1111 * (i + 1)), 1'b0, 1'b1);
        end
        chk("load_count_15", 32'(bus.load_count), 32'(15));
        for (int i = 0; i < 15; i++) begin
            chk("mem_content", 32'(tb_mem[i]), 32'(16'(16'h1111 * (i + 1))));
        end

        // Both requesters held high: loader priority bounded by the burst limit.
        for (int k = 0; k < 12; k++) begin
            step(vt[k].fr, vt[k].pc, vt[k].lr, vt[k].la, vt[k].ld, vt[k].efg, vt[k].elg);
        end
        chk("load_count_sat", 32'(bus.load_count), 32'(16));
        step(1'b0, 16'h0000, 1'b0, 4'h0, 16'h0000, 1'b0, 1'b0);

        // Write then read of the same word in the next cycle.
        step(1'b0, 16'h0000, 1'b1, 4'h5, 16'hBEEF, 1'b0, 1'b1);
        step(1'b1, 16'h000A, 1'b0, 4'h0, 16'h0000, 1'b1, 1'b0);
        chk("wr_then_rd", 32'(bus.fetch_instr), 32'(16'hBEEF));

        // Back-to-back fetches, including a wrapped and misaligned PC.
        step(1'b1, 16'h0023, 1'b0, 4'h0, 16'h0000, 1'b1, 1'b0);
        chk("wrap_misalign", 32'(bus.fetch_misalign), 32'(1));
        step(1'b1, 16'h0004, 1'b0, 4'h0, 16'h0000, 1'b1, 1'b0);
        step(1'b1, 16'h001F, 1'b0, 4'h0, 16'h0000, 1'b1, 1'b0);
        step(1'b0, 16'h001F, 1'b0, 4'h0, 16'h0000, 1'b0, 1'b0);

        // Load burst hits the limit exactly as the loader lets go.
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 16'h000C, 1'b1, 4'h6, 16'(16'h7700 + i), 1'b0, 1'b1);
        end
        step(1'b1, 16'h000C, 1'b0, 4'h0, 16'h0000, 1'b1, 1'b0);
        chk("burst_drop_instr", 32'(bus.fetch_instr), 32'(16'h7703));
        step(1'b0, 16'h000C, 1'b0, 4'h0, 16'h0000, 1'b0, 1'b0);

        // Reset asserted mid-cycle right after a fetch grant, with 7 loads committed.
        do_reset();
        for (int i = 0; i < 7; i++) begin
            step(1'b0, 16'h0000, 1'b1, 4'(8 + i), 16'(16'h3300 + i), 1'b0, 1'b1);
        end
        chk("load_count_7", 32'(bus.load_count), 32'(7));
        @(negedge clk);
        bus.fetch_req = 1'b1;
        bus.fetch_pc  = 16'h0008;
        bus.load_req  = 1'b0;
        #1;
        chk("pre_rst_fetch_gnt", 32'(bus.fetch_gnt), 32'(1));
        @(posedge clk);
        #2;
        rst          = 1'b1;
        bus.load_req = 1'b1;
        #1;
        chk("mid_rst_fetch_valid", 32'(bus.fetch_valid), 32'(0));
        chk("mid_rst_fetch_instr", 32'(bus.fetch_instr), 32'(0));
        chk("mid_rst_fetch_misalign", 32'(bus.fetch_misalign), 32'(0));
        chk("mid_rst_load_count", 32'(bus.load_count), 32'(0));
        chk("mid_rst_fetch_gnt", 32'(bus.fetch_gnt), 32'(0));
        chk("mid_rst_mem_we", 32'(bus.mem_we), 32'(0));
        @(negedge clk);
        rst           = 1'b0;
        bus.fetch_req = 1'b0;
        bus.load_req  = 1'b0;
        ref_count     = 0;
        last_instr    = '0;
        last_mis      = 1'b0;
        @(posedge clk);
        #1;
        chk("post_rst_fetch_valid", 32'(bus.fetch_valid), 32'(0));
        chk("post_rst_load_count", 32'(bus.load_count), 32'(0));
        step(1'b1, 16'h0010, 1'b0, 4'h0, 16'h0000, 1'b1, 1'b0);
        step(1'b0, 16'h0010, 1'b0, 4'h0, 16'h0000, 1'b0, 1'b0);

        chk("sb_drained", 32'(sb_q.size()), 32'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
